snoop_bus_ctrl: RTL and testbench



---
 rtl/coherence_pkg.sv | 43 ++++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/snoop_bus_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared coherence definitions: line flag encoding, snoop FSM state codes and
// the requester/remote flag transition used by the bus controller and caches.
package coherence_pkg;

  localparam logic [1:0] INVALID      = 2'd0;
  localparam logic [1:0] SHARED_CLEAN = 2'd1;
  localparam logic [1:0] OWNED_CLEAN  = 2'd2;
  localparam logic [1:0] OWNED_DIRTY  = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SNOOP   = 3'd1;
  localparam logic [2:0] ST_RESOLVE = 3'd2;
  localparam logic [2:0] ST_WB_WAIT = 3'd3;
  localparam logic [2:0] ST_UPDATE  = 3'd4;
  localparam logic [2:0] ST_GRANT   = 3'd5;

  typedef struct packed {
    logic       hit;
    logic       wb;
    logic [1:0] req_flag;
    logic [1:0] rmt_flag;
  } flag_update_t;

  // remote_flag must already be INVALID when the remote table missed
  function automatic flag_update_t next_flag(input logic is_write, input logic [1:0] remote_flag);
    flag_update_t r;
    r.hit = (remote_flag != INVALID);
    r.wb  = (remote_flag == OWNED_DIRTY);
    if (r.hit) begin
      r.req_flag = is_write ? OWNED_DIRTY : SHARED_CLEAN;
      r.rmt_flag = is_write ? INVALID : SHARED_CLEAN;
    end else begin
      r.req_flag = is_write ? OWNED_DIRTY : OWNED_CLEAN;
      r.rmt_flag = INVALID;
    end
    return r;
  endfunction

  function automatic logic [1:0] core_bit(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves to the losing core only when
// both cores contended for the accepted slot.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_winner
);

  logic r_ptr;
  logic w_both;

  assign w_both = i_req[0] & i_req[1];

  // pick the pointed core on contention, else whichever core is requesting
  always_comb begin
    if (w_both) begin
      o_winner = r_ptr;
    end else begin
      o_winner = i_req[1];
    end
  end

  // pointer update on a contested accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept && w_both) begin
      r_ptr <= ~o_winner;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Coherence initiator: arbitrates two cores, snoops the opposite tag table,
// forces a write-back on a dirty remote line and grants the requester its flag.
module snoop_bus_ctrl
  import coherence_pkg::*;
#(
  parameter int ENTRY_WIDTH  = 10,
  parameter int ADDR_P_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [ADDR_P_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_P_WIDTH-1:0] req_addr_1,
  output logic [1:0]              req_ready,
  output logic [1:0]              snp_valid,
  output logic [ADDR_P_WIDTH-1:0] snp_addr,
  input  logic [1:0]              snp_match,
  input  logic [1:0]              snp_flag_0,
  input  logic [1:0]              snp_flag_1,
  input  logic [ENTRY_WIDTH-1:0]  snp_index_0,
  input  logic [ENTRY_WIDTH-1:0]  snp_index_1,
  output logic [1:0]              rmt_we,
  output logic [ENTRY_WIDTH-1:0]  rmt_index,
  output logic [1:0]              rmt_flag,
  output logic                    wb_req,
  output logic [ADDR_P_WIDTH-1:0] wb_addr,
  input  logic                    wb_ack,
  output logic                    grant_valid,
  output logic                    grant_core,
  output logic [1:0]              grant_flag
);

  logic [2:0]              r_state;
  logic [2:0]              w_state_nxt;
  logic                    r_core;
  logic                    r_write;
  logic [ADDR_P_WIDTH-1:0] r_addr;
  logic                    r_hit_match;
  logic [1:0]              r_hit_flag;
  logic [ENTRY_WIDTH-1:0]  r_hit_index;

  logic                    w_winner;
  logic                    w_accept;
  logic [ADDR_P_WIDTH-1:0] w_win_addr;
  logic [1:0]              w_rmt_flag_in;
  flag_update_t            w_upd;

  logic [1:0]              r_req_ready;
  logic [1:0]              r_snp_valid;
  logic [ADDR_P_WIDTH-1:0] r_snp_addr;
  logic [1:0]              r_rmt_we;
  logic [ENTRY_WIDTH-1:0]  r_rmt_index;
  logic [1:0]              r_rmt_flag;
  logic                    r_wb_req;
  logic [ADDR_P_WIDTH-1:0] r_wb_addr;
  logic                    r_grant_valid;
  logic                    r_grant_core;
  logic [1:0]              r_grant_flag;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_winner (w_winner)
  );

  assign w_accept      = (r_state == ST_IDLE) && (req_valid != 2'b00);
  assign w_win_addr    = w_winner ? req_addr_1 : req_addr_0;
  assign w_rmt_flag_in = r_hit_match ? r_hit_flag : INVALID;
  assign w_upd         = next_flag(r_write, w_rmt_flag_in);

  // transaction sequencing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SNOOP;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SNOOP:   w_state_nxt = ST_RESOLVE;
      ST_RESOLVE: begin
        if (!w_upd.hit)    w_state_nxt = ST_GRANT;
        else if (w_upd.wb) w_state_nxt = ST_WB_WAIT;
        else               w_state_nxt = ST_UPDATE;
      end
      ST_WB_WAIT: begin
        if (wb_ack) w_state_nxt = ST_UPDATE;
        else        w_state_nxt = ST_WB_WAIT;
      end
      ST_UPDATE:  w_state_nxt = ST_GRANT;
      ST_GRANT:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // state, latched request and snoop response captured while snp_valid is up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_core      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= {ADDR_P_WIDTH{1'b0}};
      r_hit_match <= 1'b0;
      r_hit_flag  <= INVALID;
      r_hit_index <= {ENTRY_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_core  <= w_winner;
        r_write <= req_write[w_winner];
        r_addr  <= w_win_addr;
      end
      if (r_state == ST_SNOOP) begin
        r_hit_match <= r_core ? snp_match[0] : snp_match[1];
        r_hit_flag  <= r_core ? snp_flag_0   : snp_flag_1;
        r_hit_index <= r_core ? snp_index_0  : snp_index_1;
      end
    end
  end

  // outputs are decoded from the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready   <= 2'b00;
      r_snp_valid   <= 2'b00;
      r_snp_addr    <= {ADDR_P_WIDTH{1'b0}};
      r_rmt_we      <= 2'b00;
      r_rmt_index   <= {ENTRY_WIDTH{1'b0}};
      r_rmt_flag    <= INVALID;
      r_wb_req      <= 1'b0;
      r_wb_addr     <= {ADDR_P_WIDTH{1'b0}};
      r_grant_valid <= 1'b0;
      r_grant_core  <= 1'b0;
      r_grant_flag  <= INVALID;
    end else begin
      r_req_ready   <= w_accept ? core_bit(w_winner) : 2'b00;
      r_snp_valid   <= w_accept ? core_bit(~w_winner) : 2'b00;
      r_snp_addr    <= w_accept ? w_win_addr : {ADDR_P_WIDTH{1'b0}};
      r_wb_req      <= (w_state_nxt == ST_WB_WAIT);
      r_wb_addr     <= (w_state_nxt == ST_WB_WAIT) ? r_addr : {ADDR_P_WIDTH{1'b0}};
      r_rmt_we      <= (w_state_nxt == ST_UPDATE) ? core_bit(~r_core) : 2'b00;
      r_rmt_index   <= (w_state_nxt == ST_UPDATE) ? r_hit_index : {ENTRY_WIDTH{1'b0}};
      r_rmt_flag    <= (w_state_nxt == ST_UPDATE) ? w_upd.rmt_flag : INVALID;
      r_grant_valid <= (w_state_nxt == ST_GRANT);
      r_grant_core  <= (w_state_nxt == ST_GRANT) ? r_core : 1'b0;
      r_grant_flag  <= (w_state_nxt == ST_GRANT) ? w_upd.req_flag : INVALID;
    end
  end

  assign req_ready   = r_req_ready;
  assign snp_valid   = r_snp_valid;
  assign snp_addr    = r_snp_addr;
  assign rmt_we      = r_rmt_we;
  assign rmt_index   = r_rmt_index;
  assign rmt_flag    = r_rmt_flag;
  assign wb_req      = r_wb_req;
  assign wb_addr     = r_wb_addr;
  assign grant_valid = r_grant_valid;
  assign grant_core  = r_grant_core;
  assign grant_flag  = r_grant_flag;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-count/flag model of the protocol rules.
module tb_snoop_bus_ctrl;

  localparam int EW = 10;
  localparam int AW = 32;
  localparam logic [1:0] F_I = 2'd0, F_S = 2'd1, F_OC = 2'd2, F_OD = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_write, req_ready, snp_valid, snp_match;
  logic [AW-1:0] req_addr_0, req_addr_1, snp_addr, wb_addr;
  logic [1:0]    snp_flag_0, snp_flag_1, rmt_we, rmt_flag, grant_flag;
  logic [EW-1:0] snp_index_0, snp_index_1, rmt_index;
  logic          wb_req, wb_ack, grant_valid, grant_core;

  // tag-table contents answered while snooped; junk is driven otherwise
  logic [1:0]    tbl_match, jnk_match;
  logic [1:0]    tbl_flag [2];
  logic [EW-1:0] tbl_idx [2];
  logic [1:0]    jnk_flag;
  logic [EW-1:0] jnk_idx;

  int n_vec, n_err;

  // observations from one transaction, cycle numbers relative to request drive
  int            o_ready_cyc, o_ready_cnt, o_snp_cyc, o_snp_cnt, o_rmt_cyc, o_rmt_cnt;
  int            o_wb_cnt, o_grant_cyc;
  logic [1:0]    o_ready_val, o_snp_val, o_rmt_val, o_rmt_flag, o_grant_flag;
  logic [AW-1:0] o_snp_addr;
  logic [EW-1:0] o_rmt_idx;
  logic          o_grant_core;
  bit            o_wb_addr_bad, o_overlap;

  snoop_bus_ctrl #(.ENTRY_WIDTH(EW), .ADDR_P_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_ready(req_ready),
    .snp_valid(snp_valid), .snp_addr(snp_addr), .snp_match(snp_match),
    .snp_flag_0(snp_flag_0), .snp_flag_1(snp_flag_1),
    .snp_index_0(snp_index_0), .snp_index_1(snp_index_1),
    .rmt_we(rmt_we), .rmt_index(rmt_index), .rmt_flag(rmt_flag),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .grant_valid(grant_valid), .grant_core(grant_core), .grant_flag(grant_flag)
  );

  always #5 clk = ~clk;

  always_comb begin
    snp_match   = (snp_valid & tbl_match) | (~snp_valid & jnk_match);
    snp_flag_0  = snp_valid[0] ? tbl_flag[0] : jnk_flag;
    snp_flag_1  = snp_valid[1] ? tbl_flag[1] : jnk_flag;
    snp_index_0 = snp_valid[0] ? tbl_idx[0]  : jnk_idx;
    snp_index_1 = snp_valid[1] ? tbl_idx[1]  : jnk_idx;
  end

  task automatic test_reset();
    n_vec++; if (req_ready !== 2'b00 || snp_valid !== 2'b00 || snp_addr !== 32'd0) begin
      n_err++; $display("FAIL reset_req_snp: got ready=%b snp=%b addr=%h, expected all 0", req_ready, snp_valid, snp_addr); end
    n_vec++; if (rmt_we !== 2'b00 || rmt_index !== 10'd0 || rmt_flag !== 2'b00) begin
      n_err++; $display("FAIL reset_rmt: got we=%b idx=%h flag=%0d, expected all 0", rmt_we, rmt_index, rmt_flag); end
    n_vec++; if (wb_req !== 1'b0 || wb_addr !== 32'd0) begin
      n_err++; $display("FAIL reset_wb: got req=%b addr=%h, expected 0", wb_req, wb_addr); end
    n_vec++; if (grant_valid !== 1'b0 || grant_core !== 1'b0 || grant_flag !== 2'b00) begin
      n_err++; $display("FAIL reset_grant: got v=%b c=%b f=%0d, expected 0", grant_valid, grant_core, grant_flag); end
    rst = 1'b0;
  endtask

  // One transaction from core c; caller is at a negedge. off=1 when the DUT is
  // still in its grant cycle at the first sampling edge (back-to-back issue).
  task automatic test_txn(input bit c, input bit wr, input logic [AW-1:0] addr, input bit m,
                          input logic [1:0] f, input logic [EW-1:0] idx, input int ack,
                          input bit hold, input bit noise, input int off);
    bit hit, dirty;
    int e_grant;
    logic [1:0] e_gflag, e_rflag, e_self;
    hit     = m && (f != F_I);
    dirty   = hit && (f == F_OD);
    e_grant = off + 3 + (hit ? 1 : 0) + (dirty ? ack : 0);
    e_gflag = wr ? F_OD : (hit ? F_S : F_OC);
    e_rflag = wr ? F_I : F_S;
    e_self  = c ? 2'b10 : 2'b01;
    tbl_match[!c] = m;  tbl_flag[!c] = f;  tbl_idx[!c] = idx;
    tbl_match[c] = 1'($urandom); tbl_flag[c] = 2'($urandom); tbl_idx[c] = EW'($urandom);
    if (c) req_addr_1 = addr; else req_addr_0 = addr;
    req_write[c] = wr; req_valid[c] = 1'b1;
    o_ready_cyc = -1; o_ready_cnt = 0; o_snp_cyc = -1; o_snp_cnt = 0; o_rmt_cyc = -1; o_rmt_cnt = 0;
    o_wb_cnt = 0; o_grant_cyc = -1; o_wb_addr_bad = 1'b0; o_overlap = 1'b0;
    o_ready_val = 2'b00; o_snp_val = 2'b00; o_rmt_val = 2'b00; o_rmt_flag = 2'b00; o_grant_flag = 2'b00;
    o_snp_addr = 32'd0; o_rmt_idx = 10'd0; o_grant_core = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      jnk_match = 2'($urandom); jnk_flag = 2'($urandom); jnk_idx = EW'($urandom);
      if (req_ready != 2'b00) begin
        if (o_ready_cnt == 0) begin o_ready_cyc = k; o_ready_val = req_ready; end
        o_ready_cnt++;
        if (!hold) req_valid[c] = 1'b0;
      end
      if (snp_valid != 2'b00) begin
        if (o_snp_cnt == 0) begin o_snp_cyc = k; o_snp_val = snp_valid; o_snp_addr = snp_addr; end
        o_snp_cnt++;
      end
      if (rmt_we != 2'b00) begin
        o_rmt_cyc = k; o_rmt_cnt++; o_rmt_val = rmt_we; o_rmt_idx = rmt_index; o_rmt_flag = rmt_flag;
      end
      if (wb_req) begin
        o_wb_cnt++;
        if (wb_addr !== addr) o_wb_addr_bad = 1'b1;
      end
      wb_ack = wb_req ? (o_wb_cnt == ack) : (noise ? 1'($urandom) : 1'b0);
      if (grant_valid) begin
        if (rmt_we != 2'b00) o_overlap = 1'b1;
        o_grant_cyc = k; o_grant_core = grant_core; o_grant_flag = grant_flag;
        req_valid[c] = 1'b0; wb_ack = 1'b0;
        break;
      end
    end
    req_valid[c] = 1'b0; wb_ack = 1'b0;
    n_vec++; if (o_ready_cyc !== 1 + off || o_ready_val !== e_self || o_ready_cnt !== 1) begin
      n_err++; $display("FAIL ready: got cyc=%0d val=%b cnt=%0d, expected cyc=%0d val=%b cnt=1", o_ready_cyc, o_ready_val, o_ready_cnt, 1 + off, e_self); end
    n_vec++; if (o_snp_cyc !== 1 + off || o_snp_cnt !== 1 || o_snp_val !== ~e_self || o_snp_addr !== addr) begin
      n_err++; $display("FAIL snoop: got cyc=%0d cnt=%0d val=%b addr=%h, expected cyc=%0d cnt=1 val=%b addr=%h", o_snp_cyc, o_snp_cnt, o_snp_val, o_snp_addr, 1 + off, ~e_self, addr); end
    n_vec++; if (o_rmt_cnt !== (hit ? 1 : 0)) begin
      n_err++; $display("FAIL rmt_count: got %0d expected %0d", o_rmt_cnt, hit ? 1 : 0); end
    if (hit) begin
      n_vec++; if (o_rmt_cyc !== e_grant - 1 || o_rmt_val !== ~e_self || o_rmt_idx !== idx || o_rmt_flag !== e_rflag) begin
        n_err++; $display("FAIL rmt_update: got cyc=%0d we=%b idx=%h flag=%0d, expected cyc=%0d we=%b idx=%h flag=%0d", o_rmt_cyc, o_rmt_val, o_rmt_idx, o_rmt_flag, e_grant - 1, ~e_self, idx, e_rflag); end
    end
    n_vec++; if (o_wb_cnt !== (dirty ? ack : 0) || o_wb_addr_bad) begin
      n_err++; $display("FAIL writeback: got cycles=%0d addr_bad=%0d, expected cycles=%0d addr_bad=0", o_wb_cnt, o_wb_addr_bad, dirty ? ack : 0); end
    n_vec++; if (o_grant_cyc !== e_grant || o_grant_core !== c || o_grant_flag !== e_gflag || o_overlap) begin
      n_err++; $display("FAIL grant: got cyc=%0d core=%0d flag=%0d overlap=%0d, expected cyc=%0d core=%0d flag=%0d overlap=0", o_grant_cyc, o_grant_core, o_grant_flag, o_overlap, e_grant, c, e_gflag); end
  endtask

  task automatic test_directed();
    @(negedge clk); test_txn(1'b0, 1'b0, 32'h0000_1000, 1'b0, F_S,  10'h000, 1, 1'b0, 1'b0, 0);
    @(negedge clk); test_txn(1'b1, 1'b1, 32'h0000_2000, 1'b1, F_S,  10'h005, 1, 1'b0, 1'b0, 0);
    @(negedge clk); test_txn(1'b0, 1'b0, 32'h0000_3000, 1'b1, F_OD, 10'h3FF, 3, 1'b0, 1'b1, 0);
    @(negedge clk); test_txn(1'b1, 1'b1, 32'h0000_4000, 1'b1, F_OD, 10'h0A5, 1, 1'b0, 1'b0, 0);
    @(negedge clk); test_txn(1'b0, 1'b0, 32'h0000_5000, 1'b1, F_I,  10'h011, 1, 1'b0, 1'b0, 0);
    @(negedge clk); test_txn(1'b1, 1'b0, 32'h0000_6000, 1'b1, F_OC, 10'h022, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); test_txn(1'b0, 1'b1, 32'h0000_7000, 1'b0, F_I, 10'h000, 1, 1'b1, 1'b0, 0);
    test_txn(1'b1, 1'b0, 32'h0000_8000, 1'b1, F_S, 10'h123, 1, 1'b1, 1'b0, 1);
    test_txn(1'b0, 1'b0, 32'h0000_9000, 1'b1, F_OD, 10'h2B4, 2, 1'b0, 1'b1, 1);
  endtask

  task automatic test_arbitration();
    int rr_m, w, g;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    rr_m = 0;
    tbl_match = 2'b00; req_write = 2'b00;
    for (int p = 0; p < 3; p++) begin
      req_addr_0 = $urandom; req_addr_1 = $urandom; req_valid = 2'b11;
      w = -1;
      for (int k = 0; k < 10 && w < 0; k++) begin
        @(negedge clk);
        if (req_ready == 2'b01) w = 0; else if (req_ready == 2'b10) w = 1;
      end
      n_vec++; if (w !== rr_m) begin n_err++; $display("FAIL arb_first pair%0d: got core %0d expected core %0d", p, w, rr_m); end
      w = rr_m; rr_m = 1 - w;
      req_valid[w] = 1'b0;
      g = -1;
      for (int k = 0; k < 20 && g < 0; k++) begin @(negedge clk); if (grant_valid) g = grant_core; end
      n_vec++; if (g !== w) begin n_err++; $display("FAIL arb_grant1 pair%0d: got core %0d expected core %0d", p, g, w); end
      g = -1;
      for (int k = 0; k < 10 && g < 0; k++) begin @(negedge clk); if (req_ready != 2'b00) g = req_ready[1] ? 1 : 0; end
      n_vec++; if (g !== 1 - w) begin n_err++; $display("FAIL arb_second pair%0d: got core %0d expected core %0d", p, g, 1 - w); end
      req_valid = 2'b00;
      g = -1;
      for (int k = 0; k < 20 && g < 0; k++) begin @(negedge clk); if (grant_valid) g = grant_core; end
      n_vec++; if (g !== 1 - w) begin n_err++; $display("FAIL arb_grant2 pair%0d: got core %0d expected core %0d", p, g, 1 - w); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midwb();
    bit seen;
    int bad;
    @(negedge clk);
    tbl_match[1] = 1'b1; tbl_flag[1] = F_OD; tbl_idx[1] = 10'h155; wb_ack = 1'b0;
    req_addr_0 = 32'h0000_3000; req_write[0] = 1'b0; req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (wb_req) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rst_wb_reach: got wb_req never, expected wb_req within 10 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (wb_req !== 1'b0 || wb_addr !== 32'd0 || grant_valid !== 1'b0 || rmt_we !== 2'b00) begin
      n_err++; $display("FAIL rst_midwb: got wb_req=%b wb_addr=%h grant=%b rmt_we=%b, expected all 0", wb_req, wb_addr, grant_valid, rmt_we); end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wb_ack = 1'($urandom);
      if (grant_valid || wb_req || rmt_we != 2'b00) bad++;
    end
    wb_ack = 1'b0;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rst_drop: got %0d active cycles after reset, expected 0", bad); end
    test_txn(1'b0, 1'b0, 32'h0000_3000, 1'b1, F_OD, 10'h155, 2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    int gap, off;
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      off = (gap == 0) ? 1 : 0;
      repeat (gap) @(negedge clk);
      test_txn(1'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 3) != 0), 2'($urandom),
               EW'($urandom), $urandom_range(1, 4), 1'($urandom), 1'b1, off);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr_0 = 32'd0; req_addr_1 = 32'd0;
    wb_ack = 1'b0; tbl_match = 2'b00; jnk_match = 2'b00; jnk_flag = 2'b00; jnk_idx = 10'd0;
    tbl_flag[0] = 2'b00; tbl_flag[1] = 2'b00; tbl_idx[0] = 10'd0; tbl_idx[1] = 10'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midwb();
    test_arbitration();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
